// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Holds the width defaults, the PC alias index and a packed-slice extractor.
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam int PC_REG_DEF  = 15;
  localparam int SLICE_MAX_W = 64;
  localparam int PACK_MAX_W  = 1024;

  // Returns field idx of a packed vector made of width-bit fields, zero-extended.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(input logic [PACK_MAX_W-1:0] vec_in,
                                                       input int idx, input int width);
    logic [SLICE_MAX_W-1:0] mask;
    mask = {SLICE_MAX_W{1'b1}} >> (SLICE_MAX_W - width);
    return SLICE_MAX_W'(vec_in >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations.
// Tracks issued-but-incomplete registers and latches protocol errors.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_iss_valid,
  input  logic [ADDR_W-1:0]    i_iss_addr,
  input  logic                 i_we1,
  input  logic [ADDR_W-1:0]    i_wa1,
  output logic [2**ADDR_W-1:0] o_busy_vec,
  output logic                 o_sb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic [NREG-1:0] r_busy;
  logic            r_err;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic            w_set;
  logic            w_iss_err;
  logic            w_cmp_err;

  always_comb begin
    w_set      = i_iss_valid && (i_iss_addr != PC_ADDR);
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set) w_set_mask[i_iss_addr] = 1'b1;
    if (i_we1) w_clr_mask[i_wa1] = 1'b1;
    // A same-cycle completion legalises a re-issue, and a same-cycle issue legalises a completion.
    w_iss_err = w_set && r_busy[i_iss_addr] && !w_clr_mask[i_iss_addr];
    w_cmp_err = i_we1 && !r_busy[i_wa1] && !w_set_mask[i_wa1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_err  <= r_err | w_iss_err | w_cmp_err;
    end
  end

  assign o_busy_vec = r_busy;
  assign o_sb_err   = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports, PC alias, optional
// same-cycle bypass and a scoreboard that raises a decode stall.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 3,
  parameter int PC_REG = PC_REG_DEF,
  parameter int BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD-1:0]        i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic [DATA_W-1:0]        i_pc_in,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_wa0,
  input  logic [DATA_W-1:0]        i_wd0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_wa1,
  input  logic [DATA_W-1:0]        i_wd1,
  input  logic                     i_iss_valid,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  output logic [NUM_RD-1:0]        o_rd_busy,
  output logic                     o_stall,
  output logic [2**ADDR_W-1:0]     o_busy_vec,
  output logic                     o_sb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   w_busy_vec;

  // Port 0 is assigned last so it wins when both ports hit the same register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      if (i_we1 && (i_wa1 != PC_ADDR)) r_regs[i_wa1] <= i_wd1;
      if (i_we0 && (i_wa0 != PC_ADDR)) r_regs[i_wa0] <= i_wd0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W),
    .PC_REG(PC_REG)
  ) u_sb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_iss_valid(i_iss_valid),
    .i_iss_addr (i_iss_addr),
    .i_we1      (i_we1),
    .i_wa1      (i_wa1),
    .o_busy_vec (w_busy_vec),
    .o_sb_err   (o_sb_err)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit0;
    logic              w_hit1;

    assign w_addr = ADDR_W'(get_slice(PACK_MAX_W'(i_rd_addr), i, ADDR_W));
    assign w_hit0 = (BYPASS != 0) && i_we0 && (i_wa0 == w_addr);
    assign w_hit1 = (BYPASS != 0) && i_we1 && (i_wa1 == w_addr);

    assign o_rd_data[i*DATA_W +: DATA_W] = (w_addr == PC_ADDR) ? i_pc_in :
                                           w_hit0              ? i_wd0   :
                                           w_hit1              ? i_wd1   :
                                                                 r_regs[w_addr];

    // A completing port-1 write is forwarded, so it no longer needs to stall.
    assign o_rd_busy[i] = i_rd_en[i] && w_busy_vec[w_addr] && (w_addr != PC_ADDR) && !w_hit1;
  end

  assign o_stall    = |o_rd_busy;
  assign o_busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb, comparing a bypassing
// instance and a non-bypassing instance driven by the same stimulus.
module tb_regfile_sb;

   typedef struct {
      logic        rst;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic        we0;
      logic [3:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [3:0]  wa1;
      logic [31:0] wd1;
      logic        iss;
      logic [3:0]  issAddr;
      logic [31:0] expD0;
      logic [31:0] expD1;
      logic [31:0] expNbD0;
      logic        expStall;
      logic        expNbStall;
      logic [15:0] expBusy;
      logic        expErr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  rdEn;
   logic [11:0] rdAddr;
   logic [31:0] pcIn;
   logic        we0, we1, issValid;
   logic [3:0]  wa0, wa1, issAddr;
   logic [31:0] wd0, wd1;

   logic [95:0] rdData, nbRdData;
   logic [2:0]  rdBusy, nbRdBusy;
   logic        stall, nbStall, sbErr, nbSbErr;
   logic [15:0] busyVec, nbBusyVec;

   int passCount = 0;
   int checkCount = 0;
   vec_t vecs[19];

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut (
      .i_clk(clk), .i_reset(reset), .i_rd_en(rdEn), .i_rd_addr(rdAddr), .o_rd_data(rdData),
      .i_pc_in(pcIn), .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0), .i_we1(we1), .i_wa1(wa1),
      .i_wd1(wd1), .i_iss_valid(issValid), .i_iss_addr(issAddr), .o_rd_busy(rdBusy),
      .o_stall(stall), .o_busy_vec(busyVec), .o_sb_err(sbErr)
   );

   regfile_sb #(.BYPASS(0)) dutNb (
      .i_clk(clk), .i_reset(reset), .i_rd_en(rdEn), .i_rd_addr(rdAddr), .o_rd_data(nbRdData),
      .i_pc_in(pcIn), .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0), .i_we1(we1), .i_wa1(wa1),
      .i_wd1(wd1), .i_iss_valid(issValid), .i_iss_addr(issAddr), .o_rd_busy(nbRdBusy),
      .o_stall(nbStall), .o_busy_vec(nbBusyVec), .o_sb_err(nbSbErr)
   );

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp)
         $display("[TB] FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
      else
         passCount++;
   endtask

   // Drives one cycle of inputs just after a rising edge, leaving time to settle before the next.
   task automatic applyStimulus(input logic rst, input logic [2:0] en, input logic [3:0] a0,
                                input logic [3:0] a1, input logic [3:0] a2,
                                input logic w0, input logic [3:0] ad0, input logic [31:0] d0,
                                input logic w1, input logic [3:0] ad1, input logic [31:0] d1,
                                input logic is, input logic [3:0] ia);
      @(posedge clk);
      #1;
      reset = rst; rdEn = en; rdAddr = {a2, a1, a0};
      we0 = w0; wa0 = ad0; wd0 = d0;
      we1 = w1; wa1 = ad1; wd1 = d1;
      issValid = is; issAddr = ia;
      #3;
   endtask

   // Abort rather than hang if the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      pcIn = 32'h0000_0108;
      reset = 1'b1; rdEn = '0; rdAddr = '0;
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      issValid = 1'b0; issAddr = '0;
      repeat (2) @(posedge clk);

      // rst ra0 ra1 | we0 wa0 wd0 | we1 wa1 wd1 | iss ia | d0 d1 nbD0 | stall nbStall busy err
      vecs[0]  = '{1'b0, 4'd3, 4'd15, 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h12345678, 32'h108, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 4'd3, 4'd15, 1'b1, 4'd15, 32'hDEAD, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h12345678, 32'h108, 32'h12345678, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[2]  = '{1'b0, 4'd5, 4'd15, 1'b1, 4'd5, 32'hA, 1'b1, 4'd5, 32'hB, 1'b0, 4'd0,
                   32'hA, 32'h108, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 4'd5, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'hA, 32'h108, 32'hA, 1'b0, 1'b0, 16'h0000, 1'b1};
      vecs[4]  = '{1'b0, 4'd5, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                   32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 4'd7, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h0, 32'h108, 32'h0, 1'b1, 1'b1, 16'h0080, 1'b0};
      vecs[6]  = '{1'b0, 4'd7, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h55, 1'b0, 4'd0,
                   32'h55, 32'h108, 32'h0, 1'b0, 1'b1, 16'h0080, 1'b0};
      vecs[7]  = '{1'b0, 4'd7, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h55, 32'h108, 32'h55, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[8]  = '{1'b0, 4'd7, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4,
                   32'h55, 32'h108, 32'h55, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[9]  = '{1'b0, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h44, 1'b1, 4'd4,
                   32'h44, 32'h108, 32'h0, 1'b0, 1'b1, 16'h0010, 1'b0};
      vecs[10] = '{1'b0, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h44, 32'h108, 32'h44, 1'b1, 1'b1, 16'h0010, 1'b0};
      vecs[11] = '{1'b0, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2,
                   32'h44, 32'h108, 32'h44, 1'b1, 1'b1, 16'h0010, 1'b0};
      vecs[12] = '{1'b0, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2,
                   32'h44, 32'h108, 32'h44, 1'b1, 1'b1, 16'h0014, 1'b0};
      vecs[13] = '{1'b0, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h44, 32'h108, 32'h44, 1'b1, 1'b1, 16'h0014, 1'b1};
      vecs[14] = '{1'b1, 4'd4, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h44, 32'h108, 32'h44, 1'b1, 1'b1, 16'h0014, 1'b1};
      vecs[15] = '{1'b0, 4'd9, 4'd15, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0,
                   32'h99, 32'h108, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[16] = '{1'b0, 4'd9, 4'd15, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h99, 32'h108, 32'h99, 1'b0, 1'b0, 16'h0000, 1'b1};
      vecs[17] = '{1'b1, 4'd9, 4'd15, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1,
                   32'h99, 32'h108, 32'h99, 1'b0, 1'b0, 16'h0000, 1'b1};
      vecs[18] = '{1'b0, 4'd9, 4'd6, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                   32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0};

      for (int n = 0; n < 19; n++) begin
         applyStimulus(vecs[n].rst, 3'b011, vecs[n].ra0, vecs[n].ra1, 4'd0,
                       vecs[n].we0, vecs[n].wa0, vecs[n].wd0,
                       vecs[n].we1, vecs[n].wa1, vecs[n].wd1,
                       vecs[n].iss, vecs[n].issAddr);
         checkOutput($sformatf("v%0d rd0", n), rdData[31:0], vecs[n].expD0);
         checkOutput($sformatf("v%0d rd1", n), rdData[63:32], vecs[n].expD1);
         checkOutput($sformatf("v%0d nb_rd0", n), nbRdData[31:0], vecs[n].expNbD0);
         checkOutput($sformatf("v%0d stall", n), {31'b0, stall}, {31'b0, vecs[n].expStall});
         checkOutput($sformatf("v%0d nb_stall", n), {31'b0, nbStall}, {31'b0, vecs[n].expNbStall});
         checkOutput($sformatf("v%0d busy", n), {16'b0, busyVec}, {16'b0, vecs[n].expBusy});
         checkOutput($sformatf("v%0d nb_busy", n), {16'b0, nbBusyVec}, {16'b0, vecs[n].expBusy});
         checkOutput($sformatf("v%0d sb_err", n), {31'b0, sbErr}, {31'b0, vecs[n].expErr});
         checkOutput($sformatf("v%0d nb_sb_err", n), {31'b0, nbSbErr}, {31'b0, vecs[n].expErr});
      end

      // Read port 2: write r12 and issue it in the same cycle, then complete it.
      applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd12, 32'hCAFE,
                    1'b0, 4'd0, 32'h0, 1'b1, 4'd12);
      applyStimulus(1'b0, 3'b100, 4'd0, 4'd0, 4'd12, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      checkOutput("p2 rd2", rdData[95:64], 32'hCAFE);
      checkOutput("p2 rd_busy", {29'b0, rdBusy}, 32'h4);
      checkOutput("p2 nb_rd_busy", {29'b0, nbRdBusy}, 32'h4);
      checkOutput("p2 stall", {31'b0, stall}, 32'h1);
      applyStimulus(1'b0, 3'b100, 4'd0, 4'd0, 4'd12, 1'b0, 4'd0, 32'h0,
                    1'b1, 4'd12, 32'hBEEF, 1'b0, 4'd0);
      checkOutput("p2 cmp rd2", rdData[95:64], 32'hBEEF);
      checkOutput("p2 cmp nb_rd2", nbRdData[95:64], 32'hCAFE);
      checkOutput("p2 cmp rd_busy", {29'b0, rdBusy}, 32'h0);
      checkOutput("p2 cmp nb_rd_busy", {29'b0, nbRdBusy}, 32'h4);
      applyStimulus(1'b0, 3'b100, 4'd0, 4'd0, 4'd12, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
      checkOutput("p2 post nb_rd2", nbRdData[95:64], 32'hBEEF);
      checkOutput("p2 post nb_rd_busy", {29'b0, nbRdBusy}, 32'h0);
      checkOutput("p2 post busy", {16'b0, busyVec}, 32'h0);
      checkOutput("p2 post sb_err", {31'b0, sbErr}, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's three-ported register file.
- Configurable data width, register count and number of read ports.
- Two write ports: port 0 for ALU writeback, port 1 for long-latency completion (load/multiply).
- All writes happen on the rising clock edge, with same-cycle write-to-read bypass.
- A per-register scoreboard tracks pending long-latency destinations and raises a decode-stage stall.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 4, register address width; register count is 2**ADDR_W, including the PC alias.
- NUM_RD, 3, number of combinational read ports.
- PC_REG, 15, register index that reads the pc_in port and is never stored.
- BYPASS, 1, 1 forwards same-cycle write data to reads; 0 makes writes visible only on the next cycle.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  NUM_RD  read port i is in use by the instruction in decode.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing as rd_addr.
- pc_in  in  DATA_W  value returned for reads of PC_REG (PC+8).
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (long-latency completion; clears busy).
- iss_valid, iss_addr  in  1/ADDR_W  a long-latency op issued with destination iss_addr; marks it busy.
- rd_busy  out  NUM_RD  per-port hazard flag.
- stall  out  1  OR of rd_busy.
- busy_vec  out  2**ADDR_W  current scoreboard bits.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (synchronous, high at a rising edge):
  - all stored registers, busy_vec and sb_err clear to 0;
  - takes priority over every write, issue and clear in that cycle.
- Reads are combinational. Priority per port i:
  - addr==PC_REG -> pc_in;
  - else BYPASS && we0 && wa0==addr -> wd0;
  - else BYPASS && we1 && wa1==addr -> wd1;
  - else stored value.
- Writes:
  - occur at the rising edge;
  - writes to PC_REG are dropped;
  - we0 and we1 to the same address in one cycle: port 0 value is stored.
- Scoreboard update at each rising edge:
  - busy[wa1] cleared if we1;
  - then busy[iss_addr] set if iss_valid.
  - Set wins over clear for the same register.
  - Issue to PC_REG is ignored.
- rd_busy[i] = rd_en[i] && busy[addr_i] && addr_i!=PC_REG.
  - With BYPASS=1, rd_busy[i] is additionally masked when we1 && wa1==addr_i (data forwarded).
  - With BYPASS=0 there is no mask; stall persists one extra cycle.
- A busy register that receives a we0 write stays busy; only port 1 clears it.
- sb_err sets at the edge, and stays set until reset, if either holds:
  - iss_valid to a register already busy and not cleared by we1 this cycle;
  - we1 to a register not busy and not being set by iss_valid this cycle.
- Latency:
  - write to stored value: 1 edge;
  - issue to busy visible: 1 edge;
  - reads: 0 cycles.
- Reset mid-operation discards all pending ops. A we1 arriving after reset for a pre-reset op sets sb_err; upstream quiesces the port.

Decomposition:
- regfile_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the PC_REG constant;
  - a function to extract a packed read address / data slice.
- One sub-module, regfile_scoreboard, holds busy_vec, sb_err and the set/clear/error logic. Inputs: iss_valid, iss_addr, we1, wa1. Output: busy_vec.
- Storage and read muxing stay in regfile_sb.

Test Plan:
- Reset, then we0 r3=0x12345678 with port 0 reading r3 in the same cycle -> rd_data0 = 0x12345678 (BYPASS=1); next cycle the stored value reads back. With BYPASS=0, same-cycle read returns 0.
- Read r15 with pc_in=0x00000108; also we0 to r15=0xDEAD -> reads return 0x108 and no storage change.
- Same cycle: we0 r5=0xA, we1 r5=0xB -> same-cycle read returns 0xA; next cycle stores 0xA.
- iss r7; next cycle rd_en0 r7 -> stall=1, busy_vec[7]=1. Then we1 r7=0x55 -> stall=0 and rd_data0=0x55 same cycle; busy_vec[7]=0 next cycle.
- iss r2 twice without completion -> sb_err=1, persists; we1 r9 never issued -> sb_err=1. Reset clears sb_err, busy_vec and all registers.
- Same cycle: we1 r4 completes and iss r4 -> busy_vec[4] stays 1 and sb_err stays 0.
